// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory,
// and buffers fetched words in a 2-entry FIFO toward decode, with redirect and fault handling.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_rd,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   typedef enum logic {S_RUN, S_FAULT} state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } entry_t;

   // One past the last legal byte address; 33 bits so the compare cannot overflow.
   localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   entry_t      fifo_q [2];
   entry_t      fifo_d [2];

   logic       pop;
   logic       push;
   logic       redirect_ok;
   logic       pc_in_range;
   logic [1:0] tail;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         pc_q       <= RESET_PC;
         count_q    <= 2'd0;
         fault_pc_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   // NOTE: FIFO storage needs no reset; count_q alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   // Next-state logic: redirect outranks everything, then range fault, then push/pop.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      fault_pc_d = fault_pc_q;
      fifo_d     = fifo_q;
      push       = 1'b0;
      tail       = 2'd0;

      pop         = (count_q != 2'd0) && instr_ready;
      redirect_ok = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < PC_LIMIT);
      pc_in_range = ({1'b0, pc_q} < PC_LIMIT);

      if (redirect_valid) begin
         count_d = 2'd0;
         if (redirect_ok) begin
            pc_d    = redirect_pc;
            state_d = S_RUN;
         end else begin
            state_d    = S_FAULT;
            fault_pc_d = redirect_pc;
         end
      end else begin
         if (state_q == S_RUN) begin
            if (!pc_in_range) begin
               state_d    = S_FAULT;
               fault_pc_d = pc_q;
            end else if ((count_q < 2'd2) || pop) begin
               push = 1'b1;
               pc_d = pc_q + 32'd4;
            end
         end

         if (pop) begin
            fifo_d[0] = fifo_q[1];
         end
         tail = count_q - {1'b0, pop};
         if (push) begin
            if (tail == 2'd0) fifo_d[0] = '{word: imem_rd, pc: pc_q};
            else              fifo_d[1] = '{word: imem_rd, pc: pc_q};
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Outputs: everything reads zero during reset except the address, which shows RESET_PC.
   always_comb begin
      imem_en     = ~rst;
      imem_addr   = rst ? RESET_PC : pc_q;
      instr_valid = ~rst && (count_q != 2'd0);
      instr       = rst ? 32'h0 : fifo_q[0].word;
      instr_pc    = rst ? 32'h0 : fifo_q[0].pc;
      fault       = ~rst && (state_q == S_FAULT);
      fault_pc    = rst ? 32'h0 : fault_pc_q;
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit, plus a hand sequence on a
// 4-word instance for the out-of-range fault.
module tb_instruction_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   function automatic logic [31:0] w(input logic [9:0] idx);
      case (idx)
         10'd0:   return 32'h0033_0313;
         10'd1:   return 32'h0043_0893;
         10'd2:   return 32'h0113_06B3;
         default: return 32'hC0DE_0000 | {22'h0, idx};
      endcase
   endfunction

   // Main instance, default parameters.
   logic        rst = 1'b1, redirect_valid = 1'b0, instr_ready = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr, imem_rd, instr, instr_pc, fault_pc;
   logic        imem_en, instr_valid, fault;

   assign imem_rd = imem_en ? w(imem_addr[11:2]) : 32'h0;

   instruction_fetch_unit dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_en(imem_en), .imem_rd(imem_rd),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .fault(fault), .fault_pc(fault_pc)
   );

   // Small instance for the out-of-range check.
   logic        s_rst = 1'b1, s_rv = 1'b0, s_rdy = 1'b1;
   logic [31:0] s_rpc = 32'h0;
   logic [31:0] s_addr, s_rd, s_instr, s_ipc, s_fpc;
   logic        s_en, s_valid, s_fault;

   assign s_rd = s_en ? w(s_addr[11:2]) : 32'h0;

   instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
      .clk(clk), .rst(s_rst), .imem_addr(s_addr), .imem_en(s_en), .imem_rd(s_rd),
      .redirect_valid(s_rv), .redirect_pc(s_rpc),
      .instr_valid(s_valid), .instr_ready(s_rdy), .instr(s_instr), .instr_pc(s_ipc),
      .fault(s_fault), .fault_pc(s_fpc)
   );

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] epc;
      logic        ef;
      logic [31:0] efpc;
      logic [31:0] eaddr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] ei,
                              input logic [31:0] epc, input logic ef, input logic [31:0] efpc,
                              input logic [31:0] eaddr);
      vec_t t;
      t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.ev = ev; t.ei = ei;
      t.epc = epc; t.ef = ef; t.efpc = efpc; t.eaddr = eaddr;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      int got;

      // Reset sequencing, throughput.
      tbl.push_back(v(1,0,0,1, 0,0,0, 0,0, 0));
      tbl.push_back(v(1,0,0,1, 0,0,0, 0,0, 0));
      tbl.push_back(v(0,0,0,1, 0,0,0, 0,0, 0));
      tbl.push_back(v(0,0,0,1, 1,w(0),0, 0,0, 4));
      tbl.push_back(v(0,0,0,1, 1,w(1),4, 0,0, 8));
      tbl.push_back(v(0,0,0,1, 1,w(2),8, 0,0, 12));
      // Backpressure after a fresh reset.
      tbl.push_back(v(1,0,0,0, 0,0,0, 0,0, 0));
      tbl.push_back(v(0,0,0,0, 0,0,0, 0,0, 0));
      tbl.push_back(v(0,0,0,0, 1,w(0),0, 0,0, 4));
      tbl.push_back(v(0,0,0,0, 1,w(0),0, 0,0, 8));
      tbl.push_back(v(0,0,0,0, 1,w(0),0, 0,0, 8));
      tbl.push_back(v(0,0,0,0, 1,w(0),0, 0,0, 8));
      tbl.push_back(v(0,0,0,1, 1,w(0),0, 0,0, 8));
      tbl.push_back(v(0,0,0,1, 1,w(1),4, 0,0, 12));
      tbl.push_back(v(0,0,0,1, 1,w(2),8, 0,0, 16));
      tbl.push_back(v(0,0,0,1, 1,w(3),12, 0,0, 20));
      // Redirect to 0x20 with two entries buffered.
      tbl.push_back(v(0,0,0,0, 1,w(4),16, 0,0, 24));
      tbl.push_back(v(0,1,32'h20,1, 1,w(4),16, 0,0, 24));
      tbl.push_back(v(0,0,0,1, 0,0,0, 0,0, 32'h20));
      tbl.push_back(v(0,0,0,1, 1,w(8),32'h20, 0,0, 32'h24));
      tbl.push_back(v(0,0,0,0, 1,w(9),32'h24, 0,0, 32'h28));
      // Misaligned redirect, then recovery to 0x10.
      tbl.push_back(v(0,1,32'h22,0, 1,w(9),32'h24, 0,0, 32'h2C));
      tbl.push_back(v(0,0,0,1, 0,0,0, 1,32'h22, 32'h2C));
      tbl.push_back(v(0,0,0,1, 0,0,0, 1,32'h22, 32'h2C));
      tbl.push_back(v(0,1,32'h10,1, 0,0,0, 1,32'h22, 32'h2C));
      tbl.push_back(v(0,0,0,1, 0,0,0, 0,0, 32'h10));
      tbl.push_back(v(0,0,0,1, 1,w(4),32'h10, 0,0, 32'h14));
      tbl.push_back(v(0,0,0,0, 1,w(5),32'h14, 0,0, 32'h18));
      // Reset mid-operation with two entries buffered.
      tbl.push_back(v(1,0,0,0, 0,0,0, 0,0, 0));
      tbl.push_back(v(0,0,0,1, 0,0,0, 0,0, 0));
      tbl.push_back(v(0,0,0,1, 1,w(0),0, 0,0, 4));
      // Out-of-range redirect, then redirect to the last legal word and run off the end.
      tbl.push_back(v(0,1,32'h1000,1, 1,w(1),4, 0,0, 8));
      tbl.push_back(v(0,0,0,1, 0,0,0, 1,32'h1000, 8));
      tbl.push_back(v(0,1,32'hFFC,1, 0,0,0, 1,32'h1000, 8));
      tbl.push_back(v(0,0,0,1, 0,0,0, 0,0, 32'hFFC));
      tbl.push_back(v(0,0,0,0, 1,w(1023),32'hFFC, 0,0, 32'h1000));
      tbl.push_back(v(0,0,0,0, 1,w(1023),32'hFFC, 1,32'h1000, 32'h1000));
      tbl.push_back(v(0,0,0,1, 1,w(1023),32'hFFC, 1,32'h1000, 32'h1000));
      tbl.push_back(v(0,0,0,1, 0,0,0, 1,32'h1000, 32'h1000));

      foreach (tbl[i]) begin
         @(negedge clk);
         rst            = tbl[i].rst;
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         instr_ready    = tbl[i].rdy;
         #1;
         check($sformatf("row%0d valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].ev});
         if (tbl[i].ev) begin
            check($sformatf("row%0d instr", i), instr, tbl[i].ei);
            check($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].epc);
         end
         check($sformatf("row%0d fault", i), {31'h0, fault}, {31'h0, tbl[i].ef});
         if (tbl[i].ef || tbl[i].rst)
            check($sformatf("row%0d fault_pc", i), fault_pc, tbl[i].efpc);
         check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].eaddr);
         check($sformatf("row%0d imem_en", i), {31'h0, imem_en}, {31'h0, ~tbl[i].rst});
      end

      // IMEM_WORDS=4: four words come out, then the fetch at 0x10 faults.
      @(negedge clk);
      s_rst = 1'b1;
      @(negedge clk);
      s_rst = 1'b0;
      got = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (s_valid) begin
            if (got < 4) begin
               check($sformatf("small pc%0d", got), s_ipc, 32'(got * 4));
               check($sformatf("small instr%0d", got), s_instr, w(10'(got)));
            end
            got++;
         end
      end
      check("small delivered", 32'(got), 32'd4);
      check("small fault", {31'h0, s_fault}, 32'd1);
      check("small fault_pc", s_fpc, 32'h10);
      check("small valid", {31'h0, s_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word.
- Buffers fetched words in a 2-entry FIFO with a valid/ready handshake toward decode.
- Handles branch/jump redirects and raises a fault on misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; legal fetch byte addresses are 0 to IMEM_WORDS*4-4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- imem_addr  output  32  byte address to instruction memory (memory indexes by addr[31:2]).
- imem_en  output  1  instruction-memory enable; low forces the memory's read data to 0.
- imem_rd  input  32  read data; combinational, valid in the same cycle as imem_addr.
- redirect_valid  input  1  one-cycle pulse: load redirect_pc.
- redirect_pc  input  32  redirect target byte address.
- instr_valid  output  1  FIFO head holds an instruction.
- instr_ready  input  1  decode accepts the head this cycle.
- instr  output  32  instruction word at FIFO head.
- instr_pc  output  32  PC of the head instruction.
- fault  output  1  fetch fault latched; fetching stopped.
- fault_pc  output  32  address that caused the fault.

Behaviour:
- Reset is synchronous, sampled on the clock edge with rst=1:
  - pc=RESET_PC; FIFO count=0; state=RUN.
  - fault=0; fault_pc=0.
  - All outputs read 0 while in reset, except imem_addr=RESET_PC.
- Reset asserted mid-operation discards all buffered entries at that edge.
- imem_en = ~rst.
- imem_addr = pc at all times.
- States:
  - RUN: fetching.
  - FAULT: fetching halted.
- Push, in RUN with no redirect:
  - If count<2, or count==2 and a pop occurs in the same cycle, the entry {imem_rd, pc} is written at the tail.
  - pc advances by 4 on that edge.
  - Otherwise pc holds (stall; the same address is re-presented).
- Pop: on an edge with instr_valid && instr_ready, the head is removed.
- Simultaneous push and pop:
  - Count is unchanged.
  - At count==1 the pushed entry becomes the head on the next cycle.
- instr_valid = (count>0); instr and instr_pc come from the head.
- Throughput and latency:
  - With instr_ready held high, one instruction per cycle.
  - First instr_valid appears the cycle after the first push edge, i.e. the second cycle after reset release.
- Redirect, highest priority, evaluated on an edge with redirect_valid=1:
  - FIFO is flushed (count=0); any simultaneous push or pop is dropped.
  - If redirect_pc[1:0]==0 and redirect_pc < IMEM_WORDS*4: pc=redirect_pc, state=RUN. A redirect also clears fault, so it is the recovery path from FAULT.
  - Otherwise: state=FAULT, fault=1, fault_pc=redirect_pc.
  - instr_valid is 0 the cycle after a redirect; the target instruction is valid one cycle later.
- Range check in RUN: if pc >= IMEM_WORDS*4 at a would-be push edge:
  - No push occurs.
  - state=FAULT, fault=1, fault_pc=pc.
  - Entries already buffered remain poppable.
- FAULT state:
  - No push; pc holds.
  - Pops continue until the FIFO is empty.
  - Exit only by a legal redirect or by reset.
- Arithmetic: pc+4 is modulo 2^32; the range check makes wrap unreachable for legal IMEM_WORDS.
- instr_ready while instr_valid=0 is ignored.

Test Plan:
- Reset sequencing: memory words 0..2 = 0x00330313, 0x00430893, 0x011306B3; release rst; instr_ready=1 -> instr_valid rises in the 2nd cycle after release; instr/instr_pc sequence is 0x00330313/0, 0x00430893/4, 0x011306B3/8 on consecutive cycles.
- Backpressure: instr_ready=0 for 5 cycles -> count saturates at 2, pc holds at 8, imem_addr stable at 8; ready=1 -> PCs 0, 4, 8, 12 delivered in order with no loss or duplication.
- Redirect mid-stream: redirect_valid with redirect_pc=0x20 while 2 entries are buffered -> next cycle instr_valid=0; following cycle instr_pc=0x20; the buffered entries are never delivered.
- Misaligned redirect: redirect_pc=0x22 -> fault=1, fault_pc=0x22, instr_valid=0, pc frozen; a subsequent redirect to 0x10 -> fault=0 and instr_pc=0x10 appears.
- Out of range: IMEM_WORDS=4, run from 0 with ready=1 -> PCs 0, 4, 8, 12 delivered; then fault=1, fault_pc=0x10, and no further valid.
- Reset mid-operation: assert rst for 1 cycle while count=2 -> next cycle instr_valid=0, fault=0, imem_addr=RESET_PC; fetch restarts from RESET_PC.
